// File: rtl/add_acc_pkg.sv
// add_acc_pkg -- shared types and defaults for the add-result stream
// accumulator. Holds the two-state controller encoding, the default
// parameter values and the fixed width of the per-block word counter.
package add_acc_pkg;

  localparam int DEFAULT_IN_WIDTH  = 35;
  localparam int DEFAULT_ACC_WIDTH = 40;
  localparam int DEFAULT_BLOCK_LEN = 16;

  // Width of the word counter and of o_count; wide enough for BLOCK_LEN up to 255.
  localparam int COUNT_WIDTH = 8;

  typedef enum logic [0:0] {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } acc_state_e;

endpackage

// File: rtl/add_acc_counter.sv
// add_acc_counter -- counts the words accepted into the current block.
// The count is cleared when the finished block is handed downstream and
// flags the terminal position (BLOCK_LEN-1) so the next accept closes
// the block.
module add_acc_counter
  import add_acc_pkg::*;
#(
  parameter int BLOCK_LEN = DEFAULT_BLOCK_LEN
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_clear,
  input  logic                   i_inc,
  output logic [COUNT_WIDTH-1:0] o_cnt,
  output logic                   o_terminal
);

  localparam logic [COUNT_WIDTH-1:0] TERM_COUNT = COUNT_WIDTH'(BLOCK_LEN - 1);

  // Word counter: clear wins over increment, although the controller never
  // asserts both in the same cycle.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_cnt <= '0;
    end else if (i_clear) begin
      o_cnt <= '0;
    end else if (i_inc) begin
      o_cnt <= o_cnt + 1'b1;
    end
  end

  assign o_terminal = (o_cnt == TERM_COUNT);

endmodule

// File: rtl/add_stream_accumulator.sv
// add_stream_accumulator -- sums a stream of unsigned adder result words
// into blocks of BLOCK_LEN words (or fewer when i_last closes a block early)
// and presents each block sum on a registered valid/ready output.
//
// Optional build macro ADD_ACC_SATURATE_EN: when defined, a block whose sum
// carries out of the accumulator clamps to all-ones for the rest of the
// block; when undefined the sum wraps modulo 2^ACC_WIDTH. In both builds
// o_overflow reports that a carry-out happened during the block.
module add_stream_accumulator
  import add_acc_pkg::*;
#(
  parameter int IN_WIDTH  = DEFAULT_IN_WIDTH,
  parameter int ACC_WIDTH = DEFAULT_ACC_WIDTH,
  parameter int BLOCK_LEN = DEFAULT_BLOCK_LEN
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_valid,
  output logic                   o_ready,
  input  logic [IN_WIDTH-1:0]    i_result,
  input  logic                   i_last,
  output logic                   o_valid,
  input  logic                   i_ready,
  output logic [ACC_WIDTH-1:0]   o_sum,
  output logic [COUNT_WIDTH-1:0] o_count,
  output logic                   o_overflow
);

  acc_state_e             state;
  logic [ACC_WIDTH-1:0]   acc;
  logic                   acc_ovf;
  logic [COUNT_WIDTH-1:0] cnt;
  logic                   cnt_terminal;

  logic                   accept;
  logic                   emit;
  logic                   close_block;
  logic [ACC_WIDTH:0]     wide_sum;
  logic                   carry;
  logic [ACC_WIDTH-1:0]   next_acc;
  logic                   next_ovf;

  // Ready comes from the state alone; it is also held low while reset is
  // asserted so nothing upstream believes a word was taken during reset.
  assign o_ready = (state == ACCUM) && !i_rst;

  assign accept      = i_valid && o_ready;
  assign emit        = o_valid && i_ready;
  assign close_block = accept && (cnt_terminal || i_last);

  // One extra bit on the adder exposes the carry out of the accumulator.
  assign wide_sum = {1'b0, acc} + {{(ACC_WIDTH + 1 - IN_WIDTH){1'b0}}, i_result};
  assign carry    = wide_sum[ACC_WIDTH];
  assign next_ovf = acc_ovf || carry;

`ifdef ADD_ACC_SATURATE_EN
  // Once the block has overflowed the sum is pinned at all-ones until emit.
  assign next_acc = next_ovf ? {ACC_WIDTH{1'b1}} : wide_sum[ACC_WIDTH-1:0];
`else
  assign next_acc = wide_sum[ACC_WIDTH-1:0];
`endif

  add_acc_counter #(
    .BLOCK_LEN (BLOCK_LEN)
  ) u_counter (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_clear    (emit),
    .i_inc      (accept),
    .o_cnt      (cnt),
    .o_terminal (cnt_terminal)
  );

  // Controller: collect words in ACCUM, park the finished block in HOLD
  // until the downstream side takes it.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state <= ACCUM;
    end else begin
      case (state)
        ACCUM:   if (close_block) state <= HOLD;
        HOLD:    if (emit)        state <= ACCUM;
        default: state <= ACCUM;
      endcase
    end
  end

  // Running sum and sticky overflow for the block being collected; both are
  // left alone in HOLD and cleared when the block is emitted.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      acc     <= '0;
      acc_ovf <= 1'b0;
    end else if (emit) begin
      acc     <= '0;
      acc_ovf <= 1'b0;
    end else if (accept) begin
      acc     <= next_acc;
      acc_ovf <= next_ovf;
    end
  end

  // Registered block result: captured on the closing accept so it appears
  // one cycle later and stays frozen until the emit drops o_valid.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_valid    <= 1'b0;
      o_sum      <= '0;
      o_count    <= '0;
      o_overflow <= 1'b0;
    end else if (close_block) begin
      o_valid    <= 1'b1;
      o_sum      <= next_acc;
      o_count    <= cnt + 1'b1;
      o_overflow <= next_ovf;
    end else if (emit) begin
      o_valid    <= 1'b0;
    end
  end

endmodule

// File: tb/tb_add_stream_accumulator.sv
// tb_add_stream_accumulator -- directed self-checking bench. Three copies of
// the accumulator share one stimulus stream: default parameters, a 36-bit
// accumulator for the overflow case, and BLOCK_LEN = 1 for back-to-back blocks.
module tb_add_stream_accumulator;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        valid = 1'b0;
  logic        last = 1'b0;
  logic        rdy = 1'b0;
  logic [34:0] result = '0;

  logic        d_ready, d_valid, d_ovf;
  logic [39:0] d_sum;
  logic [7:0]  d_count;

  logic        w_ready, w_valid, w_ovf;
  logic [35:0] w_sum;
  logic [7:0]  w_count;

  logic        b_ready, b_valid, b_ovf;
  logic [39:0] b_sum;
  logic [7:0]  b_count;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  add_stream_accumulator dut_default (
    .i_clk (clk), .i_rst (rst), .i_valid (valid), .o_ready (d_ready),
    .i_result (result), .i_last (last), .o_valid (d_valid), .i_ready (rdy),
    .o_sum (d_sum), .o_count (d_count), .o_overflow (d_ovf)
  );

  add_stream_accumulator #(.ACC_WIDTH (36)) dut_wide (
    .i_clk (clk), .i_rst (rst), .i_valid (valid), .o_ready (w_ready),
    .i_result (result), .i_last (last), .o_valid (w_valid), .i_ready (rdy),
    .o_sum (w_sum), .o_count (w_count), .o_overflow (w_ovf)
  );

  add_stream_accumulator #(.BLOCK_LEN (1)) dut_blk1 (
    .i_clk (clk), .i_rst (rst), .i_valid (valid), .o_ready (b_ready),
    .i_result (result), .i_last (last), .o_valid (b_valid), .i_ready (rdy),
    .o_sum (b_sum), .o_count (b_count), .o_overflow (b_ovf)
  );

  // Pulse reset across one full clock period, leaving inputs idle.
  task automatic pulse_reset();
    @(negedge clk);
    rst = 1'b1; valid = 1'b0; last = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; valid = 1'b1; result = 35'd9;
    @(negedge clk);
    checks++; if (d_ready !== 1'b0) begin failures++; $display("[TB] FAIL reset_ready: got %0b expected 0", d_ready); end
    checks++; if (d_valid !== 1'b0) begin failures++; $display("[TB] FAIL reset_valid: got %0b expected 0", d_valid); end
    checks++; if (d_sum !== 40'd0) begin failures++; $display("[TB] FAIL reset_sum: got %0d expected 0", d_sum); end
    checks++; if (d_count !== 8'd0) begin failures++; $display("[TB] FAIL reset_count: got %0d expected 0", d_count); end
    checks++; if (d_ovf !== 1'b0) begin failures++; $display("[TB] FAIL reset_ovf: got %0b expected 0", d_ovf); end
    valid = 1'b0;
    rst = 1'b0;
    #1;
    checks++; if (d_ready !== 1'b1) begin failures++; $display("[TB] FAIL release_ready: got %0b expected 1", d_ready); end
  endtask

  task automatic test_full_block();
    pulse_reset();
    rdy = 1'b1;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (i > 0) begin
        checks++; if (d_valid !== 1'b0) begin failures++; $display("[TB] FAIL full_early_valid: word %0d got %0b expected 0", i, d_valid); end
      end
      valid = 1'b1; result = 35'd1; last = 1'b0;
    end
    @(negedge clk);
    valid = 1'b0;
    checks++; if (d_valid !== 1'b1) begin failures++; $display("[TB] FAIL full_valid: got %0b expected 1", d_valid); end
    checks++; if (d_sum !== 40'd16) begin failures++; $display("[TB] FAIL full_sum: got %0d expected 16", d_sum); end
    checks++; if (d_count !== 8'd16) begin failures++; $display("[TB] FAIL full_count: got %0d expected 16", d_count); end
    checks++; if (d_ovf !== 1'b0) begin failures++; $display("[TB] FAIL full_ovf: got %0b expected 0", d_ovf); end
    checks++; if (d_ready !== 1'b0) begin failures++; $display("[TB] FAIL full_hold_ready: got %0b expected 0", d_ready); end
    @(negedge clk);
    checks++; if (d_valid !== 1'b0) begin failures++; $display("[TB] FAIL full_pulse_end: got %0b expected 0", d_valid); end
    checks++; if (d_ready !== 1'b1) begin failures++; $display("[TB] FAIL full_ready_back: got %0b expected 1", d_ready); end
  endtask

  task automatic test_last_early();
    logic [34:0] words [3];
    words[0] = 35'd5; words[1] = 35'd7; words[2] = 35'd9;
    pulse_reset();
    rdy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      valid = 1'b1; result = words[i]; last = (i == 2);
    end
    @(negedge clk);
    valid = 1'b0; last = 1'b0;
    checks++; if (d_valid !== 1'b1) begin failures++; $display("[TB] FAIL last_valid: got %0b expected 1", d_valid); end
    checks++; if (d_sum !== 40'd21) begin failures++; $display("[TB] FAIL last_sum: got %0d expected 21", d_sum); end
    checks++; if (d_count !== 8'd3) begin failures++; $display("[TB] FAIL last_count: got %0d expected 3", d_count); end
    @(negedge clk);
  endtask

  task automatic test_backpressure();
    pulse_reset();
    rdy = 1'b0;
    @(negedge clk); valid = 1'b1; result = 35'd10; last = 1'b0;
    @(negedge clk); valid = 1'b1; result = 35'd20; last = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      valid = 1'b1; result = 35'd100; last = 1'b1;
      checks++; if (d_ready !== 1'b0) begin failures++; $display("[TB] FAIL bp_ready: cycle %0d got %0b expected 0", k, d_ready); end
      checks++; if (d_valid !== 1'b1) begin failures++; $display("[TB] FAIL bp_valid: cycle %0d got %0b expected 1", k, d_valid); end
      checks++; if (d_sum !== 40'd30) begin failures++; $display("[TB] FAIL bp_sum: cycle %0d got %0d expected 30", k, d_sum); end
      checks++; if (d_count !== 8'd2) begin failures++; $display("[TB] FAIL bp_count: cycle %0d got %0d expected 2", k, d_count); end
    end
    @(negedge clk);
    rdy = 1'b1;
    @(negedge clk);
    checks++; if (d_valid !== 1'b0) begin failures++; $display("[TB] FAIL bp_emit_valid: got %0b expected 0", d_valid); end
    checks++; if (d_ready !== 1'b1) begin failures++; $display("[TB] FAIL bp_emit_ready: got %0b expected 1", d_ready); end
    @(negedge clk);
    valid = 1'b0; last = 1'b0;
    checks++; if (d_valid !== 1'b1) begin failures++; $display("[TB] FAIL bp_next_valid: got %0b expected 1", d_valid); end
    checks++; if (d_sum !== 40'd100) begin failures++; $display("[TB] FAIL bp_next_sum: got %0d expected 100", d_sum); end
    checks++; if (d_count !== 8'd1) begin failures++; $display("[TB] FAIL bp_next_count: got %0d expected 1", d_count); end
    @(negedge clk);
    checks++; if (d_valid !== 1'b0) begin failures++; $display("[TB] FAIL bp_next_drop: got %0b expected 0", d_valid); end
  endtask

  task automatic test_overflow();
    logic [35:0] exp_wide;
`ifdef ADD_ACC_SATURATE_EN
    exp_wide = 36'hFFFFFFFFF;
`else
    exp_wide = 36'hFFFFFFFF0;
`endif
    pulse_reset();
    rdy = 1'b1;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      valid = 1'b1; result = 35'h7FFFFFFFF; last = 1'b0;
    end
    @(negedge clk);
    valid = 1'b0;
    checks++; if (w_valid !== 1'b1) begin failures++; $display("[TB] FAIL ovf_valid: got %0b expected 1", w_valid); end
    checks++; if (w_sum !== exp_wide) begin failures++; $display("[TB] FAIL ovf_sum: got %h expected %h", w_sum, exp_wide); end
    checks++; if (w_ovf !== 1'b1) begin failures++; $display("[TB] FAIL ovf_flag: got %0b expected 1", w_ovf); end
    checks++; if (w_count !== 8'd16) begin failures++; $display("[TB] FAIL ovf_count: got %0d expected 16", w_count); end
    checks++; if (d_sum !== 40'h7FFFFFFFF0) begin failures++; $display("[TB] FAIL ovf_wide40_sum: got %h expected 7ffffffff0", d_sum); end
    checks++; if (d_ovf !== 1'b0) begin failures++; $display("[TB] FAIL ovf_wide40_flag: got %0b expected 0", d_ovf); end
    @(negedge clk);
    checks++; if (w_ovf !== 1'b1) begin failures++; $display("[TB] FAIL ovf_after_emit: got %0b expected 1 (held output)", w_ovf); end
  endtask

  task automatic test_reset_mid_block();
    pulse_reset();
    rdy = 1'b1;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      valid = 1'b1; result = 35'd5; last = 1'b0;
    end
    @(negedge clk);
    valid = 1'b0;
    rst = 1'b1;
    #1;
    checks++; if (d_ready !== 1'b0) begin failures++; $display("[TB] FAIL mid_rst_ready: got %0b expected 0", d_ready); end
    checks++; if (b_valid !== 1'b0) begin failures++; $display("[TB] FAIL mid_rst_pending_valid: got %0b expected 0", b_valid); end
    checks++; if (b_sum !== 40'd0) begin failures++; $display("[TB] FAIL mid_rst_pending_sum: got %0d expected 0", b_sum); end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk); valid = 1'b1; result = 35'd3; last = 1'b0;
    @(negedge clk); valid = 1'b1; result = 35'd3; last = 1'b1;
    @(negedge clk);
    valid = 1'b0; last = 1'b0;
    checks++; if (d_valid !== 1'b1) begin failures++; $display("[TB] FAIL mid_valid: got %0b expected 1", d_valid); end
    checks++; if (d_sum !== 40'd6) begin failures++; $display("[TB] FAIL mid_sum: got %0d expected 6", d_sum); end
    checks++; if (d_count !== 8'd2) begin failures++; $display("[TB] FAIL mid_count: got %0d expected 2", d_count); end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    pulse_reset();
    rdy = 1'b1;
    @(negedge clk);
    valid = 1'b1; result = 35'd4; last = 1'b0;
    @(negedge clk);
    checks++; if (b_valid !== 1'b1) begin failures++; $display("[TB] FAIL b2b_first_valid: got %0b expected 1", b_valid); end
    checks++; if (b_sum !== 40'd4) begin failures++; $display("[TB] FAIL b2b_first_sum: got %0d expected 4", b_sum); end
    checks++; if (b_count !== 8'd1) begin failures++; $display("[TB] FAIL b2b_first_count: got %0d expected 1", b_count); end
    checks++; if (b_ready !== 1'b0) begin failures++; $display("[TB] FAIL b2b_first_hold_ready: got %0b expected 0", b_ready); end
    result = 35'd8;
    @(negedge clk);
    checks++; if (b_valid !== 1'b0) begin failures++; $display("[TB] FAIL b2b_gap_valid: got %0b expected 0", b_valid); end
    checks++; if (b_ready !== 1'b1) begin failures++; $display("[TB] FAIL b2b_gap_ready: got %0b expected 1", b_ready); end
    @(negedge clk);
    valid = 1'b0;
    checks++; if (b_valid !== 1'b1) begin failures++; $display("[TB] FAIL b2b_second_valid: got %0b expected 1", b_valid); end
    checks++; if (b_sum !== 40'd8) begin failures++; $display("[TB] FAIL b2b_second_sum: got %0d expected 8", b_sum); end
    checks++; if (b_ready !== 1'b0) begin failures++; $display("[TB] FAIL b2b_second_hold_ready: got %0b expected 0", b_ready); end
    @(negedge clk);
    checks++; if (b_valid !== 1'b0) begin failures++; $display("[TB] FAIL b2b_done_valid: got %0b expected 0", b_valid); end
  endtask

  // Safety net so the run always ends even if the sequence stalls.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    test_reset();
    test_full_block();
    test_last_early();
    test_backpressure();
    test_overflow();
    test_reset_mid_block();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/add_stream_accumulator.md
ADD_STREAM_ACCUMULATOR -- requirements
Module: add_stream_accumulator

Interface
REQ-001 SHALL have parameter IN_WIDTH, default 35; width of one adder result word (carry-out plus sum).
REQ-002 SHALL have parameter ACC_WIDTH, default 40; width of the running sum; ACC_WIDTH > IN_WIDTH.
REQ-003 SHALL have parameter BLOCK_LEN, default 16; number of accepted words per output block; range 1..255.
REQ-004 SHALL have one clock and an asynchronous, active-high reset, named i_clk and i_rst.
REQ-005 i_clk  input  1  clock; all state changes on the rising edge.
REQ-006 i_rst  input  1  asynchronous, active-high reset.
REQ-007 i_valid  input  1  upstream word valid.
REQ-008 o_ready  output  1  block can accept a word.
REQ-009 i_result  input  IN_WIDTH  unsigned adder result word.
REQ-010 i_last  input  1  qualified by i_valid; closes the block early.
REQ-011 o_valid  output  1  block sum available.
REQ-012 i_ready  input  1  downstream accepts the block sum.
REQ-013 o_sum  output  ACC_WIDTH  block sum.
REQ-014 o_count  output  8  number of words in the emitted block.
REQ-015 o_overflow  output  1  block sum exceeded ACC_WIDTH, sticky per block.

Function
REQ-016 SHALL implement two states: ACCUM and HOLD.
- Accept = i_valid & o_ready.
- Emit = o_valid & i_ready.
REQ-017 In ACCUM, o_ready SHALL be 1; in HOLD, o_ready SHALL be 0.
REQ-018 On accept:
- acc <= acc + zero-extended i_result, modulo 2^ACC_WIDTH.
- cnt <= cnt + 1.
REQ-019 An accept SHALL close the block when cnt+1 == BLOCK_LEN or i_last == 1. On the next edge:
- o_sum = acc + i_result;
- o_count = cnt + 1;
- o_valid = 1;
- state = HOLD.
REQ-020 Latency SHALL be one cycle from the closing accept to o_valid.
REQ-021 In HOLD, o_sum, o_count and o_overflow SHALL stay stable until emit.
REQ-022 On emit, the block SHALL:
- clear acc, cnt and the overflow flag;
- drop o_valid the next cycle;
- return to ACCUM.
There is no same-cycle accept, because o_ready is 0 in HOLD.
REQ-023 The overflow flag SHALL set when any block addition carries out of bit ACC_WIDTH-1, and SHALL hold until emit.
REQ-024 i_valid without o_ready SHALL leave all state unchanged.
REQ-025 i_last on the first word of a block SHALL emit a block with o_count = 1.
REQ-026 Outputs SHALL be registered; o_ready SHALL be decoded from state only.

Reset
REQ-027 On reset assertion, the block SHALL immediately force:
- state = ACCUM;
- acc, cnt = 0;
- o_valid, o_overflow = 0;
- o_sum, o_count = 0.
REQ-028 While i_rst = 1, o_ready SHALL be 0.
REQ-029 Reset asserted mid-block or in HOLD SHALL discard the partial or pending sum, with no emit.

Configuration
REQ-030 Macro ADD_ACC_SATURATE_EN SHALL select overflow handling:
- Defined: on overflow, the running sum SHALL clamp to all-ones, stay there for the block, and o_overflow SHALL still assert.
- Undefined: the sum SHALL wrap modulo 2^ACC_WIDTH.

Structure
REQ-031 Package add_acc_pkg SHALL hold:
- the state enum (ACCUM, HOLD);
- default constants for IN_WIDTH, ACC_WIDTH and BLOCK_LEN;
- the count width, 8.
REQ-032 Sub-module add_acc_counter SHALL hold cnt: clear on emit, increment on accept, terminal-count flag at BLOCK_LEN-1.

Verification
REQ-033 Defaults; 16 words of value 1, i_ready = 1 → one o_valid pulse with o_sum = 16, o_count = 16, o_overflow = 0, one cycle after the 16th accept.
REQ-034 Values 5, 7, 9 with i_last on 9 → o_sum = 21, o_count = 3.
REQ-035 Block closed, i_ready held 0 for 10 cycles with i_valid = 1 → o_ready = 0, o_sum stable, no words lost; first word after emit starts a new block at acc = 0.
REQ-036 ACC_WIDTH = 36; 16 words of 2^35-1 → without the macro, o_sum = (16·(2^35-1)) mod 2^36 with o_overflow = 1; with the macro, o_sum = 2^36-1 with o_overflow = 1.
REQ-037 Reset pulsed after 7 accepts, then 2 words of value 3 with i_last on the second → o_sum = 6, o_count = 2.
REQ-038 BLOCK_LEN = 1; words 4 and 8 back-to-back with i_ready = 1 → two blocks, o_sum = 4 then 8, with o_ready = 0 in each HOLD cycle.
